// File: rtl/mem_sequencer_if.sv
// Instruction handshake plus datapath control bundle between the issuing
// unit (master) and the memory/ALU sequencer (slave).
interface mem_sequencer_if;
   logic        instr_valid;
   logic        instr_ready;
   logic [2:0]  op;
   logic [4:0]  rd, rn, rm;
   logic [63:0] imm;

   logic        W, EN_B, EN_ALU, EN_ADDR, K_SEL, C0, WE, OE;
   logic [4:0]  SA, SB, DA, FS;
   logic [63:0] K;
   logic        done, err;

   modport master (
      output instr_valid, op, rd, rn, rm, imm,
      input  instr_ready, W, EN_B, EN_ALU, EN_ADDR, K_SEL, C0, WE, OE,
             SA, SB, DA, FS, K, done, err
   );

   modport slave (
      input  instr_valid, op, rd, rn, rm, imm,
      output instr_ready, W, EN_B, EN_ALU, EN_ADDR, K_SEL, C0, WE, OE,
             SA, SB, DA, FS, K, done, err
   );
endinterface

// File: rtl/mem_sequencer.sv
// Multi-cycle control sequencer: accepts one instruction at a time and steps
// the regfile/ALU/memory datapath strobes through the required phases.
module mem_sequencer #(
   parameter logic [4:0] FS_ADD = 5'b01000,
   parameter logic [4:0] FS_SUB = 5'b01001
) (
   input  logic            clk,
   input  logic            rst,
   mem_sequencer_if.slave  bus
);

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_ADDI = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_LDUR = 3'b100;
   localparam logic [2:0] OP_STUR = 3'b101;

   typedef enum logic [2:0] {
      IDLE, EXEC, LD_ADDR, LD_DATA, ST_SETUP, ST_WRITE, RETIRE
   } state_t;

   typedef struct packed {
      logic [2:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rn;
      logic [4:0]  rm;
      logic [63:0] imm;
   } instr_t;

   state_t state, state_nxt;
   instr_t ins;
   logic   xfer;

   // ready is gated by rst so nothing is claimed as accepted while in reset
   assign bus.instr_ready = (state == IDLE) && rst;
   assign xfer            = bus.instr_valid && bus.instr_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         ins   <= '0;
      end else begin
         state <= state_nxt;
         if (xfer)
            ins <= '{op: bus.op, rd: bus.rd, rn: bus.rn, rm: bus.rm, imm: bus.imm};
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (xfer) begin
               case (bus.op)
                  OP_ADD, OP_ADDI, OP_SUB: state_nxt = EXEC;
                  OP_LDUR:                 state_nxt = LD_ADDR;
                  OP_STUR:                 state_nxt = ST_SETUP;
                  default:                 state_nxt = RETIRE;
               endcase
            end
         end
         EXEC:     state_nxt = RETIRE;
         LD_ADDR:  state_nxt = LD_DATA;
         LD_DATA:  state_nxt = RETIRE;
         ST_SETUP: state_nxt = ST_WRITE;
         ST_WRITE: state_nxt = RETIRE;
         RETIRE:   state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Outputs depend only on state and the latched instruction; the async
   // reset of state forces everything low without waiting for clk.
   always_comb begin
      bus.W       = 1'b0;
      bus.EN_B    = 1'b0;
      bus.EN_ALU  = 1'b0;
      bus.EN_ADDR = 1'b0;
      bus.K_SEL   = 1'b0;
      bus.C0      = 1'b0;
      bus.WE      = 1'b0;
      bus.OE      = 1'b0;
      bus.SA      = '0;
      bus.SB      = '0;
      bus.DA      = '0;
      bus.FS      = '0;
      bus.K       = '0;
      bus.done    = 1'b0;
      bus.err     = 1'b0;
      case (state)
         EXEC: begin
            bus.SA     = ins.rn;
            bus.SB     = ins.rm;
            bus.DA     = ins.rd;
            bus.EN_ALU = 1'b1;
            bus.W      = 1'b1;
            case (ins.op)
               OP_ADDI: begin
                  bus.FS    = FS_ADD;
                  bus.K_SEL = 1'b1;
                  bus.K     = ins.imm;
               end
               OP_SUB: begin
                  bus.FS = FS_SUB;
                  bus.C0 = 1'b1;
               end
               default: bus.FS = FS_ADD;
            endcase
         end
         LD_ADDR, LD_DATA: begin
            bus.SA      = ins.rn;
            bus.K       = ins.imm;
            bus.K_SEL   = 1'b1;
            bus.FS      = FS_ADD;
            bus.EN_ADDR = 1'b1;
            bus.OE      = 1'b1;
            if (state == LD_DATA) begin
               bus.W  = 1'b1;
               bus.DA = ins.rd;
            end
         end
         ST_SETUP, ST_WRITE: begin
            bus.SA      = ins.rn;
            bus.SB      = ins.rd;
            bus.K       = ins.imm;
            bus.K_SEL   = 1'b1;
            bus.FS      = FS_ADD;
            bus.EN_ADDR = 1'b1;
            bus.EN_B    = 1'b1;
            bus.WE      = (state == ST_WRITE);
         end
         RETIRE: begin
            bus.done = 1'b1;
            bus.err  = (ins.op[2:1] == 2'b11);
         end
         default: ;
      endcase
   end

   // NOP is a legal op that simply retires; named here for readability
   logic unused_nop;
   assign unused_nop = (ins.op == OP_NOP);

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer with a small regfile/memory model that
// executes whatever the control strobes ask for.
module tb_mem_sequencer;
   localparam logic [4:0] FS_ADD = 5'b01000;
   localparam logic [4:0] FS_SUB = 5'b01001;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   logic [63:0] r [32];
   logic [63:0] mem [logic [63:0]];

   mem_sequencer_if bus();

   mem_sequencer #(.FS_ADD(FS_ADD), .FS_SUB(FS_SUB)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [4:0] d, n, m, input logic [63:0] i);
      bus.instr_valid = 1'b1;
      bus.op = o; bus.rd = d; bus.rn = n; bus.rm = m; bus.imm = i;
   endtask

   task automatic idle_in;
      bus.instr_valid = 1'b0;
      bus.op = '0; bus.rd = '0; bus.rn = '0; bus.rm = '0; bus.imm = '0;
   endtask

   // Datapath model, evaluated mid-cycle, plus bus exclusivity checks
   always @(negedge clk) begin
      logic [63:0] a, b, addr;
      if (rst) begin
         a    = r[bus.SA];
         b    = bus.K_SEL ? bus.K : r[bus.SB];
         addr = a + bus.K;
         if (bus.EN_ALU && bus.W)
            r[bus.DA] = (bus.FS == FS_SUB) ? a + ~b + 64'(bus.C0) : a + b;
         if (bus.EN_ADDR && bus.WE)
            mem[addr] = r[bus.SB];
         if (bus.EN_ADDR && bus.OE && bus.W)
            r[bus.DA] = mem.exists(addr) ? mem[addr] : 64'h0;
         chk("one_bus_driver", 64'(($countones({bus.EN_B, bus.EN_ALU, bus.OE}) <= 1)), 64'h1);
         chk("we_oe_excl", 64'(bus.WE && bus.OE), 64'h0);
         chk("w_enb_excl", 64'(bus.W && bus.EN_B), 64'h0);
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) r[i] = 64'h0;
      r[1]  = 64'd10;
      r[4]  = 64'hDEAD;
      r[31] = 64'd7;
      idle_in();
      rst = 1'b0;
      #1;
      chk("rst_done", 64'(bus.done), 64'h0);
      chk("rst_err", 64'(bus.err), 64'h0);
      chk("rst_strobes", 64'({bus.W, bus.EN_B, bus.EN_ALU, bus.EN_ADDR, bus.K_SEL, bus.C0, bus.WE, bus.OE}), 64'h0);
      chk("rst_addr", 64'({bus.SA, bus.SB, bus.DA, bus.FS}), 64'h0);
      chk("rst_k", bus.K, 64'h0);
      #11 rst = 1'b1;
      #1;
      chk("ready_after_rst", 64'(bus.instr_ready), 64'h1);

      // ADDI r2 = r1 + 5; inputs change while busy and must be ignored
      issue(3'b010, 5'd2, 5'd1, 5'd0, 64'd5);
      step();
      issue(3'b101, 5'd9, 5'd9, 5'd9, 64'h77);
      chk("addi_ksel", 64'(bus.K_SEL), 64'h1);
      chk("addi_k", bus.K, 64'd5);
      chk("addi_enalu", 64'(bus.EN_ALU), 64'h1);
      chk("addi_w", 64'(bus.W), 64'h1);
      chk("addi_da", 64'(bus.DA), 64'd2);
      chk("addi_sa", 64'(bus.SA), 64'd1);
      chk("addi_fs", 64'(bus.FS), 64'(FS_ADD));
      chk("addi_ready", 64'(bus.instr_ready), 64'h0);
      chk("addi_nodone", 64'(bus.done), 64'h0);
      step();
      idle_in();
      chk("addi_done", 64'(bus.done), 64'h1);
      chk("addi_noerr", 64'(bus.err), 64'h0);
      chk("retire_w", 64'(bus.W), 64'h0);
      chk("retire_k", bus.K, 64'h0);
      chk("retire_da", 64'(bus.DA), 64'h0);
      step();
      chk("addi_ready_again", 64'(bus.instr_ready), 64'h1);
      chk("addi_done_pulse", 64'(bus.done), 64'h0);
      chk("addi_r2", r[2], 64'd15);

      // SUB r3 = r1 - r2 = 10 - 15
      issue(3'b011, 5'd3, 5'd1, 5'd2, 64'h0);
      step();
      idle_in();
      chk("sub_fs", 64'(bus.FS), 64'(FS_SUB));
      chk("sub_c0", 64'(bus.C0), 64'h1);
      chk("sub_sb", 64'(bus.SB), 64'd2);
      chk("sub_ksel", 64'(bus.K_SEL), 64'h0);
      step();
      chk("sub_done", 64'(bus.done), 64'h1);
      step();
      chk("sub_r3", r[3], 64'hFFFF_FFFF_FFFF_FFFB);

      // STUR r4 -> [r0 + 0x1008]
      issue(3'b101, 5'd4, 5'd0, 5'd0, 64'h1008);
      step();
      idle_in();
      chk("st_setup_enaddr", 64'(bus.EN_ADDR), 64'h1);
      chk("st_setup_enb", 64'(bus.EN_B), 64'h1);
      chk("st_setup_we", 64'(bus.WE), 64'h0);
      chk("st_setup_sb", 64'(bus.SB), 64'd4);
      chk("st_setup_k", bus.K, 64'h1008);
      chk("st_setup_oe", 64'(bus.OE), 64'h0);
      step();
      chk("st_write_we", 64'(bus.WE), 64'h1);
      chk("st_write_enb", 64'(bus.EN_B), 64'h1);
      chk("st_write_oe", 64'(bus.OE), 64'h0);
      chk("st_write_nodone", 64'(bus.done), 64'h0);
      step();
      chk("st_done", 64'(bus.done), 64'h1);
      chk("st_retire_we", 64'(bus.WE), 64'h0);
      step();
      chk("st_mem", mem.exists(64'h1008) ? mem[64'h1008] : 64'hX, 64'hDEAD);

      // LDUR r5 <- [r0 + 0x1008]
      issue(3'b100, 5'd5, 5'd0, 5'd0, 64'h1008);
      step();
      idle_in();
      chk("ld_addr_oe", 64'(bus.OE), 64'h1);
      chk("ld_addr_w", 64'(bus.W), 64'h0);
      chk("ld_addr_enalu", 64'(bus.EN_ALU), 64'h0);
      chk("ld_addr_enaddr", 64'(bus.EN_ADDR), 64'h1);
      step();
      chk("ld_data_oe", 64'(bus.OE), 64'h1);
      chk("ld_data_w", 64'(bus.W), 64'h1);
      chk("ld_data_da", 64'(bus.DA), 64'd5);
      chk("ld_data_enalu", 64'(bus.EN_ALU), 64'h0);
      chk("ld_data_enb", 64'(bus.EN_B), 64'h0);
      step();
      chk("ld_done", 64'(bus.done), 64'h1);
      step();
      chk("ld_r5", r[5], 64'hDEAD);

      // Illegal op retires next cycle with err
      issue(3'b111, 5'd1, 5'd1, 5'd1, 64'h5);
      step();
      idle_in();
      chk("ill_done", 64'(bus.done), 64'h1);
      chk("ill_err", 64'(bus.err), 64'h1);
      chk("ill_strobes", 64'({bus.W, bus.EN_B, bus.EN_ALU, bus.EN_ADDR, bus.WE, bus.OE}), 64'h0);
      step();
      chk("ill_ready", 64'(bus.instr_ready), 64'h1);
      chk("ill_err_pulse", 64'(bus.err), 64'h0);

      // NOP
      issue(3'b000, 5'd0, 5'd0, 5'd0, 64'h0);
      step();
      idle_in();
      chk("nop_done", 64'(bus.done), 64'h1);
      chk("nop_err", 64'(bus.err), 64'h0);
      step();

      // Register 31 is an ordinary register
      issue(3'b001, 5'd31, 5'd31, 5'd31, 64'h0);
      step();
      idle_in();
      chk("r31_addr", 64'({bus.SA, bus.SB, bus.DA}), 64'h7FFF);
      chk("r31_fs", 64'(bus.FS), 64'(FS_ADD));
      step();
      step();
      chk("r31_val", r[31], 64'd14);

      // Reset pulse during ST_WRITE aborts the store
      issue(3'b101, 5'd4, 5'd0, 5'd0, 64'h2000);
      step();
      idle_in();
      step();
      chk("abort_we_before", 64'(bus.WE), 64'h1);
      #2 rst = 1'b0;
      #1;
      chk("abort_we_async", 64'(bus.WE), 64'h0);
      chk("abort_enb_async", 64'(bus.EN_B), 64'h0);
      chk("abort_done", 64'(bus.done), 64'h0);
      #4 rst = 1'b1;
      #1;
      chk("abort_ready", 64'(bus.instr_ready), 64'h1);
      step();
      chk("abort_no_done", 64'(bus.done), 64'h0);
      chk("abort_no_write", 64'(mem.exists(64'h2000)), 64'h0);

      // Normal ADD afterwards: r6 = r1 + r4
      issue(3'b001, 5'd6, 5'd1, 5'd4, 64'h0);
      step();
      idle_in();
      chk("post_add_enalu", 64'(bus.EN_ALU), 64'h1);
      step();
      chk("post_add_done", 64'(bus.done), 64'h1);
      step();
      chk("post_add_r6", r[6], 64'hDEB7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 Parameter FS_ADD, default 5'b01000, ALU function-select code for add.
REQ-002 Parameter FS_SUB, default 5'b01001, ALU function-select code for subtract, used with C0=1.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 instr_valid  input  1  upstream presents an instruction.
REQ-006 instr_ready  output  1  sequencer can accept an instruction.
REQ-007 op  input  3  000 NOP, 001 ADD, 010 ADDI, 011 SUB, 100 LDUR, 101 STUR, 110/111 illegal.
REQ-008 rd, rn, rm  input  5 each  destination/store-data, base/first-operand and second-operand register numbers.
REQ-009 imm  input  64  immediate or address offset.
REQ-010 W, EN_B, EN_ALU, EN_ADDR, K_SEL, C0, WE, OE  output  1 each  datapath control strobes.
REQ-011 SA, SB, DA, FS  output  5 each  regfile read/write addresses and ALU function select.
REQ-012 K  output  64  constant to datapath.
REQ-013 done  output  1  one-cycle pulse, instruction retired.
REQ-014 err  output  1  one-cycle pulse, illegal opcode retired.

Function
REQ-015 The sequencer SHALL hold states IDLE, EXEC, LD_ADDR, LD_DATA, ST_SETUP, ST_WRITE and RETIRE.
REQ-016 instr_ready SHALL be 1 only in IDLE; a transfer occurs on a rising edge with instr_valid=1 and instr_ready=1.
REQ-017 On transfer, op, rd, rn, rm and imm SHALL be latched; all control outputs SHALL be driven only from state and latched fields, never directly from instruction inputs.
REQ-018 Transfer transitions: ADD/ADDI/SUB -> EXEC; LDUR -> LD_ADDR; STUR -> ST_SETUP; NOP or illegal -> RETIRE.
REQ-019 EXEC (1 cycle): SA=rn, SB=rm, DA=rd, EN_ALU=1, W=1; ADD: FS=FS_ADD, K_SEL=0, C0=0; ADDI: FS=FS_ADD, K_SEL=1, K=imm, C0=0; SUB: FS=FS_SUB, K_SEL=0, C0=1; next RETIRE.
REQ-020 LD_ADDR (1 cycle): SA=rn, K=imm, K_SEL=1, FS=FS_ADD, EN_ADDR=1, OE=1, W=0; next LD_DATA.
REQ-021 LD_DATA (1 cycle): same address controls held, OE=1, W=1, DA=rd, EN_ALU=0, EN_B=0; next RETIRE.
REQ-022 ST_SETUP (1 cycle): SA=rn, SB=rd, K=imm, K_SEL=1, FS=FS_ADD, EN_ADDR=1, EN_B=1, WE=0; next ST_WRITE.
REQ-023 ST_WRITE (1 cycle): ST_SETUP controls held plus WE=1; next RETIRE.
REQ-024 RETIRE (1 cycle): all strobes 0, done=1, err=1 only if latched op is 110/111; next IDLE.
REQ-025 In IDLE and RETIRE, W, EN_B, EN_ALU, EN_ADDR, WE, OE, K_SEL and C0 SHALL be 0; SA, SB, DA, FS SHALL be 0; K SHALL be 0.
REQ-026 Bus exclusivity, every cycle: at most one of EN_B, EN_ALU, OE SHALL be 1; WE and OE SHALL never both be 1; W SHALL never be 1 with EN_B.
REQ-027 Latency from transfer edge to done: ALU ops 2 cycles, loads/stores 3 cycles, NOP/illegal 1 cycle; next transfer SHALL be possible on the edge after done.
REQ-028 instr_valid while instr_ready=0 SHALL be ignored and SHALL NOT alter latched fields.
REQ-029 DA=31 and rn/rm=31 SHALL be passed through without special handling.

Reset
REQ-030 rst=0 SHALL force IDLE, clear latched fields, and drive every control output, done and err to 0 immediately, without waiting for clk.
REQ-031 Reset asserted mid-instruction SHALL abort it; a write strobe (W or WE) SHALL deassert asynchronously, and no done SHALL be produced for the aborted instruction.
REQ-032 After rst returns to 1, instr_ready SHALL be 1 from the first cycle.

Verification
REQ-033 ADDI op=010, rd=2, rn=1, imm=5 -> cycle+1: K_SEL=1, K=5, EN_ALU=1, W=1, DA=2, FS=FS_ADD; cycle+2: done=1; ready=1 at cycle+3.
REQ-034 SUB op=011, rd=3, rn=1, rm=2 -> EXEC shows FS=FS_SUB, C0=1, SB=2, K_SEL=0; done 2 cycles after transfer.
REQ-035 STUR op=101, rd=4, rn=0, imm=0x1008 -> ST_SETUP: EN_ADDR=1, EN_B=1, WE=0, SB=4; ST_WRITE: WE=1; done 3 cycles after transfer; OE=0 throughout.
REQ-036 LDUR op=100, rd=5, rn=0, imm=0x1008, with a prior STUR of 0xDEAD to 0x1008 -> r5=0xDEAD after done; EN_ALU=0 in both load cycles.
REQ-037 op=111 -> RETIRE next cycle with done=1, err=1, no strobe asserted.
REQ-038 rst=0 pulsed during ST_WRITE -> WE falls without a clock edge, no done; a following ADD completes normally.
